multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control state machine for the multicycle MIPS datapath. It sequences fetch, decode, execute, memory and write-back for R-type, lw, sw, beq, j and addi. It drives every datapath enable and mux select. It is the producer of the 2-bit `aluOp` that the ALU control decoder turns into a 4-bit ALU operation. Memory accesses stall on a ready handshake.

## Interface
- No parameters; opcode values and state encodings are fixed below.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `opCode` input 6: instruction bits [31:26] from the instruction register; sampled only in DECODE.
- `memReady` input 1: memory completes the current access this cycle.
- `pcWrite` output 1: unconditional PC load.
- `pcWriteCond` output 1: PC load if ALU zero (branch).
- `pcSource` output 2: PC mux select. 00 is the ALU result, 01 is ALUOut, 10 is the jump target.
- `iorD` output 1: memory address select. 0 selects PC, 1 selects ALUOut.
- `memRead` output 1: memory read request.
- `memWrite` output 1: memory write request.
- `irWrite` output 1: instruction register load.
- `memToReg` output 1: register write data select. 1 selects MDR.
- `regDst` output 1: write register select. 1 selects rd, 0 selects rt.
- `regWrite` output 1: register file write.
- `aluSrcA` output 1: ALU A select. 0 selects PC, 1 selects register A.
- `aluSrcB` output 2: ALU B select. 00 is B, 01 is 4, 10 is sign-extended immediate, 11 is the shifted immediate.
- `aluOp` output 2: 00 selects add, 01 selects subtract (branch), 10 selects funct decode.
- `state` output 4: current state, for debug.
- `illegalOp` output 1: one-cycle pulse when DECODE sees an unsupported opcode.

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- States are encoded as FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11. Codes 12–15 are unused and return to FETCH on the next edge with all outputs 0.
- Outputs are Moore, except that `pcWrite`/`irWrite` in FETCH are qualified by `memReady`. Every output not listed for a state is 0.
- FETCH:
  - Outputs: `memRead`=1, `iorD`=0, `aluSrcA`=0, `aluSrcB`=01, `aluOp`=00, `pcSource`=00.
  - `irWrite`=`pcWrite`=`memReady`.
  - Goes to DECODE when `memReady`=1, otherwise stays in FETCH.
- DECODE:
  - Outputs: `aluSrcA`=0, `aluSrcB`=11, `aluOp`=00.
  - Next state by opcode: lw/sw go to MEMADR, R-type to EXEC, beq to BRANCH, j to JUMP, addi to ADDIEX.
  - Any other opcode goes to FETCH with `illegalOp`=1 for this cycle.
- MEMADR:
  - Outputs: `aluSrcA`=1, `aluSrcB`=10, `aluOp`=00.
  - Goes to MEMRD for lw or MEMWR for sw. The opcode is latched in DECODE; it is not re-sampled here.
- MEMRD: `memRead`=1, `iorD`=1. Holds until `memReady`, then goes to MEMWB.
- MEMWB: `regWrite`=1, `memToReg`=1, `regDst`=0. Goes to FETCH.
- MEMWR: `memWrite`=1, `iorD`=1. Holds until `memReady`, then goes to FETCH.
- EXEC: `aluSrcA`=1, `aluSrcB`=00, `aluOp`=10. Goes to RWB.
- RWB: `regWrite`=1, `regDst`=1, `memToReg`=0. Goes to FETCH.
- BRANCH: `aluSrcA`=1, `aluSrcB`=00, `aluOp`=01, `pcWriteCond`=1, `pcSource`=01. Goes to FETCH.
- JUMP: `pcWrite`=1, `pcSource`=10. Goes to FETCH.
- ADDIEX: `aluSrcA`=1, `aluSrcB`=10, `aluOp`=00. Goes to ADDIWB.
- ADDIWB: `regWrite`=1, `regDst`=0, `memToReg`=0. Goes to FETCH.

## Timing
- Reset behaviour:
  - While `rst`=1, all outputs are 0 and `state` reads 0.
  - The first FETCH output cycle is the first cycle after `rst` falls.
  - `rst` asserted in any state aborts the instruction on the next edge, with no further writes.
- Cycles per instruction with `memReady` held at 1: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4. Each wait cycle on `memReady` in FETCH/MEMRD/MEMWR adds exactly 1.
- `memRead`/`memWrite` stay asserted and stable for every wait cycle.
- Write enables (`regWrite`, `memWrite`, `pcWrite`, `irWrite`) never assert in two consecutive states for the same instruction, except that `memWrite` holds across MEMWR wait cycles.
- `illegalOp` is high only in the DECODE cycle that detects the bad opcode.

## Configuration
- `MC_ADDI_EN` defined: the ADDIEX and ADDIWB states exist, and addi executes as specified.
- Undefined: states 10 and 11 are not generated. Opcode 001000 is treated as illegal: DECODE goes to FETCH and `illegalOp` pulses.

## Test plan
- Reset then lw with `memReady`=1 (`opCode`=100011) -> states 0,1,2,3,4,0. `regWrite`=1 and `memToReg`=1 only in state 4. Total 5 cycles.
- R-type (`opCode`=000000) -> `aluOp`=10 in EXEC. `regWrite`=1 with `regDst`=1 in RWB. Back in FETCH after 4 cycles.
- beq (`opCode`=000100) -> BRANCH shows `aluOp`=01, `pcWriteCond`=1, `pcSource`=01. 3 cycles total.
- sw with `memReady` held 0 for 3 cycles in MEMWR -> `memWrite`=1 for 4 consecutive cycles, then FETCH. 7 cycles total.
- `opCode`=111111 -> `illegalOp` pulses in DECODE only, FETCH next, no write enables asserted. Repeat with `opCode`=001000 with `MC_ADDI_EN` undefined: same result.
- `rst` asserted during MEMRD -> next cycle all outputs are 0 and `state`=0. After release, FETCH proceeds normally.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for the multicycle MIPS datapath.
// It sequences fetch, decode, execute, memory and write-back, and drives
// every datapath enable and mux select. Memory accesses wait on memReady.
// Build option: define MC_ADDI_EN to add the addi states (ADDIEX/ADDIWB).
// Without it, opcode 001000 is decoded as illegal.
//
// state  | meaning
// -------+----------------------------------------------
// FETCH  | read instruction at PC, PC+4 (waits on memReady)
// DECODE | read registers, compute branch target, dispatch
// MEMADR | effective address for lw/sw
// MEMRD  | data read (waits on memReady)
// MEMWB  | load result written to rt
// MEMWR  | data write (waits on memReady)
// EXEC   | R-type ALU operation
// RWB    | R-type result written to rd
// BRANCH | beq compare and conditional PC load
// JUMP   | jump target loaded into PC
// ADDIEX | addi ALU operation (MC_ADDI_EN only)
// ADDIWB | addi result written to rt (MC_ADDI_EN only)

module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opCode,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic [1:0] pcSource,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       memToReg,
    output logic       regDst,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [3:0] state,
    output logic       illegalOp
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
`ifdef MC_ADDI_EN
        ,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
`endif
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [5:0] op_q;

    // State register; opcode captured at the end of DECODE so MEMADR
    // does not depend on the instruction register staying stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= 6'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)
                op_q <= opCode;
        end
    end

    // Next-state and Moore outputs; reset forces every output low
    // immediately so an aborted instruction issues no further writes.
    always_comb begin
        state_d     = S_FETCH;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        pcSource    = 2'b00;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memToReg    = 1'b0;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        aluOp       = 2'b00;
        illegalOp   = 1'b0;

        case (state_q)
            S_FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                irWrite = memReady;
                pcWrite = memReady;
                state_d = memReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                aluSrcB = 2'b11;
                case (opCode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    default: begin
                        illegalOp = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
                state_d = memReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
            end
            S_MEMWR: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
                state_d  = memReady ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                aluSrcA = 1'b1;
                aluOp   = 2'b10;
                state_d = S_RWB;
            end
            S_RWB: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = 2'b01;
                pcWriteCond = 1'b1;
                pcSource    = 2'b01;
            end
            S_JUMP: begin
                pcWrite  = 1'b1;
                pcSource = 2'b10;
            end
`ifdef MC_ADDI_EN
            S_ADDIEX: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regWrite = 1'b1;
            end
`endif
            default: state_d = S_FETCH;
        endcase

        if (rst) begin
            state_d     = S_FETCH;
            pcWrite     = 1'b0;
            pcWriteCond = 1'b0;
            pcSource    = 2'b00;
            iorD        = 1'b0;
            memRead     = 1'b0;
            memWrite    = 1'b0;
            irWrite     = 1'b0;
            memToReg    = 1'b0;
            regDst      = 1'b0;
            regWrite    = 1'b0;
            aluSrcA     = 1'b0;
            aluSrcB     = 2'b00;
            aluOp       = 2'b00;
            illegalOp   = 1'b0;
        end
    end

    assign state = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl (default build, addi disabled).
// Expected outputs come from a per-state output table and an
// instruction-level sequence model with random memReady wait cycles.

module tb_multicycle_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] opCode;
    logic       memReady;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic       memToReg, regDst, regWrite, aluSrcA, illegalOp;
    logic [1:0] pcSource, aluSrcB, aluOp;
    logic [3:0] state;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opCode(opCode), .memReady(memReady),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .pcSource(pcSource),
        .iorD(iorD), .memRead(memRead), .memWrite(memWrite),
        .irWrite(irWrite), .memToReg(memToReg), .regDst(regDst),
        .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
        .aluOp(aluOp), .state(state), .illegalOp(illegalOp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [3:0] st;
        logic       illegal;
    } obs_t;

    typedef struct {
        logic [5:0] op;
        logic       rdy;
        logic [3:0] st;
        logic       ill;
    } step_t;

    int tests  = 0;
    int errors = 0;

    function automatic obs_t observe();
        obs_t o;
        o.pc_write      = pcWrite;
        o.pc_write_cond = pcWriteCond;
        o.pc_source     = pcSource;
        o.iord          = iorD;
        o.mem_read      = memRead;
        o.mem_write     = memWrite;
        o.ir_write      = irWrite;
        o.mem_to_reg    = memToReg;
        o.reg_dst       = regDst;
        o.reg_write     = regWrite;
        o.alu_src_a     = aluSrcA;
        o.alu_src_b     = aluSrcB;
        o.alu_op        = aluOp;
        o.st            = state;
        o.illegal       = illegalOp;
        return o;
    endfunction

    // Output table written from the per-state output lists.
    function automatic obs_t expect_out(logic [3:0] st, logic rdy, logic ill);
        obs_t o;
        o    = '0;
        o.st = st;
        case (st)
            4'd0: begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
            4'd1: begin o.alu_src_b = 2'b11; o.illegal = ill; end
            4'd2: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            4'd3: begin o.mem_read = 1; o.iord = 1; end
            4'd4: begin o.reg_write = 1; o.mem_to_reg = 1; end
            4'd5: begin o.mem_write = 1; o.iord = 1; end
            4'd6: begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            4'd7: begin o.reg_write = 1; o.reg_dst = 1; end
            4'd8: begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1; o.pc_source = 2'b01; end
            4'd9: begin o.pc_write = 1; o.pc_source = 2'b10; end
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic check(string name, obs_t exp_o);
        obs_t got;
        got = observe();
        tests++;
        if (got !== exp_o) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h (state got %0d exp %0d)",
                     name, $time, got, exp_o, got.st, exp_o.st);
        end
    endtask

    // Drive one cycle: inputs set just after a rising edge, outputs
    // sampled mid-cycle, then advance past the next edge.
    task automatic apply_step(string name, logic [3:0] st, logic rdy, logic ill);
        memReady = rdy;
        #3;
        check(name, expect_out(st, rdy, ill));
        @(posedge clk);
        #1;
    endtask

    // Instruction-level model: the state sequence follows directly from
    // the instruction class plus the number of memory wait cycles.
    task automatic run_instr(logic [5:0] op, int fwait, int mwait);
        step_t q[$];
        for (int i = 0; i < fwait; i++) q.push_back('{op, 1'b0, 4'd0, 1'b0});
        q.push_back('{op, 1'b1, 4'd0, 1'b0});
        case (op)
            6'b100011: begin
                q.push_back('{op, 1'($urandom), 4'd1, 1'b0});
                q.push_back('{op, 1'($urandom), 4'd2, 1'b0});
                for (int i = 0; i < mwait; i++) q.push_back('{op, 1'b0, 4'd3, 1'b0});
                q.push_back('{op, 1'b1, 4'd3, 1'b0});
                q.push_back('{op, 1'($urandom), 4'd4, 1'b0});
            end
            6'b101011: begin
                q.push_back('{op, 1'($urandom), 4'd1, 1'b0});
                q.push_back('{op, 1'($urandom), 4'd2, 1'b0});
                for (int i = 0; i < mwait; i++) q.push_back('{op, 1'b0, 4'd5, 1'b0});
                q.push_back('{op, 1'b1, 4'd5, 1'b0});
            end
            6'b000000: begin
                q.push_back('{op, 1'($urandom), 4'd1, 1'b0});
                q.push_back('{op, 1'($urandom), 4'd6, 1'b0});
                q.push_back('{op, 1'($urandom), 4'd7, 1'b0});
            end
            6'b000100: begin
                q.push_back('{op, 1'($urandom), 4'd1, 1'b0});
                q.push_back('{op, 1'($urandom), 4'd8, 1'b0});
            end
            6'b000010: begin
                q.push_back('{op, 1'($urandom), 4'd1, 1'b0});
                q.push_back('{op, 1'($urandom), 4'd9, 1'b0});
            end
            default: q.push_back('{op, 1'($urandom), 4'd1, 1'b1});
        endcase
        opCode = op;
        foreach (q[i]) begin
            apply_step("rand", q[i].st, q[i].rdy, q[i].ill);
            // Instruction register contents are irrelevant after DECODE.
            if (q[i].st == 4'd1) opCode = 6'($urandom);
        end
    endtask

    step_t tbl[$];

    function automatic void add(logic [5:0] op, logic rdy, logic [3:0] st, logic ill);
        tbl.push_back('{op, rdy, st, ill});
    endfunction

    logic [5:0] ops [7];

    initial begin
        rst      = 1'b1;
        opCode   = 6'd0;
        memReady = 1'b0;

        #1;
        check("reset_hold", '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        memReady = 1'b1;
        #2;
        check("reset_hold_ready", '0);
        rst = 1'b0;
        #1;

        // lw, R-type, beq, sw with 3 waits, illegal 111111, addi (disabled).
        add(6'h23, 1, 0, 0); add(6'h23, 1, 1, 0); add(6'h23, 1, 2, 0);
        add(6'h23, 1, 3, 0); add(6'h23, 1, 4, 0);
        add(6'h00, 1, 0, 0); add(6'h00, 1, 1, 0); add(6'h00, 1, 6, 0);
        add(6'h00, 1, 7, 0);
        add(6'h04, 1, 0, 0); add(6'h04, 1, 1, 0); add(6'h04, 1, 8, 0);
        add(6'h2b, 1, 0, 0); add(6'h2b, 1, 1, 0); add(6'h2b, 1, 2, 0);
        add(6'h2b, 0, 5, 0); add(6'h2b, 0, 5, 0); add(6'h2b, 0, 5, 0);
        add(6'h2b, 1, 5, 0);
        add(6'h3f, 1, 0, 0); add(6'h3f, 1, 1, 1);
        add(6'h08, 1, 0, 0); add(6'h08, 1, 1, 1);
        add(6'h02, 0, 0, 0); add(6'h02, 1, 0, 0); add(6'h02, 0, 1, 0);
        add(6'h02, 0, 9, 0);
        add(6'h00, 0, 0, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            opCode = tbl[i].op;
            apply_step("table", tbl[i].st, tbl[i].rdy, tbl[i].ill);
        end

        // Reset during a stalled MEMRD: outputs drop at once and stay low.
        opCode = 6'h23;
        apply_step("rst_seq", 0, 1, 0);
        apply_step("rst_seq", 1, 1, 0);
        apply_step("rst_seq", 2, 1, 0);
        apply_step("rst_seq", 3, 0, 0);
        apply_step("rst_seq", 3, 0, 0);
        rst      = 1'b1;
        memReady = 1'b1;
        #3;
        check("rst_in_memrd", '0);
        @(posedge clk);
        #1;
        check("rst_after_edge", '0);
        rst = 1'b0;
        opCode = 6'h00;
        apply_step("post_rst", 0, 1, 0);
        apply_step("post_rst", 1, 1, 0);
        apply_step("post_rst", 6, 1, 0);
        apply_step("post_rst", 7, 1, 0);

        ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2b; ops[3] = 6'h04;
        ops[4] = 6'h02; ops[5] = 6'h08; ops[6] = 6'h3f;
        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            else op = ops[$urandom_range(0, 6)];
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
        end
        apply_step("final_fetch", 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
